// File: rtl/dxm_mux_sel_sync_pkg.sv
// Shared types and constants for the blanking channel multiplexer.
// Holds the FSM state encoding, the settle counter width and an elaboration helper.
package dxm_mux_pkg;

  typedef enum logic {
    StActive = 1'b0,
    StSettle = 1'b1
  } state_e;

  localparam int unsigned CntW = 8;

  function automatic int unsigned clog2(int unsigned v);
    int unsigned r = 0;
    int unsigned p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/dxm_mux_sel_sync_if.sv
// Lane, request/acknowledge and output bundle of the blanking channel multiplexer.
// The master side supplies lanes and requests; the slave side is the multiplexer.
interface dxm_mux_sel_sync_if #(
  parameter int unsigned MUX_WIDTH = 1,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned SEL_W     = 2
);

  logic [NUM_CH*MUX_WIDTH-1:0] in_data;
  logic                        sel_req;
  logic [SEL_W-1:0]            sel_idx;
  logic                        sel_ack;
  logic                        sel_err;
  logic                        busy;
  logic [SEL_W-1:0]            cur_sel;
  logic [MUX_WIDTH-1:0]        out_data;
  logic                        out_valid;

  modport master (
    output in_data, sel_req, sel_idx,
    input  sel_ack, sel_err, busy, cur_sel, out_data, out_valid
  );

  modport slave (
    input  in_data, sel_req, sel_idx,
    output sel_ack, sel_err, busy, cur_sel, out_data, out_valid
  );

endinterface

// File: rtl/dxm_settle_cnt.sv
// Loadable down-counter that times the blanking window.
// Saturates at zero; zero flag is combinational from the count.
module dxm_settle_cnt
  import dxm_mux_pkg::*;
#(
  parameter logic [CntW-1:0] ResetVal = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [CntW-1:0] load_val,
  output logic            zero
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= ResetVal;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dxm_mux_sel_sync.sv
// Registered N-channel lane multiplexer with request/ack switching.
// Output is forced invalid and zero for SETTLE_CYCLES cycles around every real switch.
module dxm_mux_sel_sync
  import dxm_mux_pkg::*;
#(
  parameter int unsigned MUX_WIDTH     = 1,
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned SEL_W         = 2,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input logic                clk,
  input logic                rst,
  dxm_mux_sel_sync_if.slave  bus
);

  localparam int unsigned     NumSlots   = 1 << SEL_W;
  localparam logic [SEL_W:0]  NumChW     = (SEL_W + 1)'(NUM_CH);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $fatal(1, "dxm_mux_sel_sync: SETTLE_CYCLES must be in 1..255");
  end
  if (NUM_CH < 2 || clog2(NUM_CH) > SEL_W) begin : g_bad_sel_w
    $fatal(1, "dxm_mux_sel_sync: need NUM_CH >= 2 and 2**SEL_W >= NUM_CH");
  end

  // Unused select codes map to zero lanes so indexing never leaves the array.
  logic [MUX_WIDTH-1:0] lanes [NumSlots];
  for (genvar k = 0; k < NumSlots; k++) begin : g_lane
    if (k < NUM_CH) begin : g_used
      assign lanes[k] = bus.in_data[k*MUX_WIDTH +: MUX_WIDTH];
    end else begin : g_pad
      assign lanes[k] = '0;
    end
  end

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     pend_q, pend_d;
  logic [SEL_W-1:0]     cur_q, cur_d;
  logic                 from_rst_q, from_rst_d;
  logic [MUX_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 cnt_load, cnt_en, cnt_zero;

  dxm_settle_cnt #(
    .ResetVal (SettleLoad)
  ) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (SettleLoad),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    cur_d      = cur_q;
    from_rst_d = from_rst_q;
    data_d     = '0;
    valid_d    = 1'b0;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    unique case (state_q)
      StActive: begin
        data_d  = lanes[cur_q];
        valid_d = 1'b1;
        if (bus.sel_req) begin
          if ({1'b0, bus.sel_idx} >= NumChW) begin
            err_d = 1'b1;
          end else if (bus.sel_idx == cur_q) begin
            ack_d = 1'b1;
          end else begin
            state_d    = StSettle;
            pend_d     = bus.sel_idx;
            from_rst_d = 1'b0;
            cnt_load   = 1'b1;
            data_d     = '0;
            valid_d    = 1'b0;
          end
        end
      end
      StSettle: begin
        // Requests arriving here, exit edge included, are dropped.
        if (cnt_zero) begin
          state_d = StActive;
          cur_d   = pend_q;
          data_d  = lanes[pend_q];
          valid_d = 1'b1;
          ack_d   = ~from_rst_q;
        end else begin
          cnt_en = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StSettle;
      pend_q     <= '0;
      cur_q      <= '0;
      from_rst_q <= 1'b1;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      cur_q      <= cur_d;
      from_rst_q <= from_rst_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
    end
  end

  assign bus.sel_ack   = ack_q;
  assign bus.sel_err   = err_q;
  assign bus.busy      = (state_q == StSettle);
  assign bus.cur_sel   = cur_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_dxm_mux_sel_sync.sv
// Bench for dxm_mux_sel_sync: a 4-channel and a 3-channel instance share stimulus
// and are compared every cycle against a blanking-window reference model.
module tb_dxm_mux_sel_sync;

  localparam int Settle = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [1:0]  idx;
  logic [15:0] din;

  always #5 clk = ~clk;

  dxm_mux_sel_sync_if #(.MUX_WIDTH(4), .NUM_CH(4), .SEL_W(2)) bus4 ();
  dxm_mux_sel_sync_if #(.MUX_WIDTH(4), .NUM_CH(3), .SEL_W(2)) bus3 ();

  assign bus4.in_data = din;
  assign bus4.sel_req = req;
  assign bus4.sel_idx = idx;
  assign bus3.in_data = din[11:0];
  assign bus3.sel_req = req;
  assign bus3.sel_idx = idx;

  dxm_mux_sel_sync #(
    .MUX_WIDTH(4), .NUM_CH(4), .SEL_W(2), .SETTLE_CYCLES(Settle)
  ) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  dxm_mux_sel_sync #(
    .MUX_WIDTH(4), .NUM_CH(3), .SEL_W(2), .SETTLE_CYCLES(Settle)
  ) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Model: committed channel, blanked cycles still to come, target and ack owed.
  int          nch [2] = '{4, 3};
  int          m_cur [2];
  int          m_blank [2];
  int          m_tgt [2];
  bit          m_owe [2];
  logic        e_valid [2];
  logic        e_busy [2];
  logic        e_ack [2];
  logic        e_err [2];
  logic [3:0]  e_data [2];

  int checks = 0;
  int errors = 0;

  function automatic logic [3:0] lane(logic [15:0] d, int ch);
    return d[ch*4 +: 4];
  endfunction

  task automatic model_edge(int k);
    e_ack[k] = 1'b0;
    e_err[k] = 1'b0;
    if (rst) begin
      m_cur[k]   = 0;
      m_tgt[k]   = 0;
      m_blank[k] = Settle;
      m_owe[k]   = 1'b0;
    end else if (m_blank[k] > 0) begin
      m_blank[k]--;
      if (m_blank[k] == 0) begin
        m_cur[k] = m_tgt[k];
        e_ack[k] = m_owe[k];
      end
    end else if (req) begin
      if (int'(idx) >= nch[k]) begin
        e_err[k] = 1'b1;
      end else if (int'(idx) == m_cur[k]) begin
        e_ack[k] = 1'b1;
      end else begin
        m_tgt[k]   = int'(idx);
        m_blank[k] = Settle;
        m_owe[k]   = 1'b1;
      end
    end
    e_busy[k]  = (m_blank[k] > 0);
    e_valid[k] = !e_busy[k];
    e_data[k]  = e_valid[k] ? lane(din, m_cur[k]) : 4'h0;
  endtask

  task automatic chk(string tag, int k, logic [3:0] obs, logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h t=%0t", tag, k, obs, exp, $time);
    end
  endtask

  task automatic check_all(int k);
    logic       ov, ob, oa, oe;
    logic [3:0] od;
    logic [1:0] oc;
    if (k == 0) begin
      ov = bus4.out_valid; ob = bus4.busy; oa = bus4.sel_ack; oe = bus4.sel_err;
      od = bus4.out_data;  oc = bus4.cur_sel;
    end else begin
      ov = bus3.out_valid; ob = bus3.busy; oa = bus3.sel_ack; oe = bus3.sel_err;
      od = bus3.out_data;  oc = bus3.cur_sel;
    end
    chk("out_valid", k, {3'b0, ov}, {3'b0, e_valid[k]});
    chk("busy",      k, {3'b0, ob}, {3'b0, e_busy[k]});
    chk("sel_ack",   k, {3'b0, oa}, {3'b0, e_ack[k]});
    chk("sel_err",   k, {3'b0, oe}, {3'b0, e_err[k]});
    chk("out_data",  k, od, e_data[k]);
    chk("cur_sel",   k, {2'b0, oc}, {2'b0, 2'(m_cur[k])});
  endtask

  task automatic step(bit r, bit q, logic [1:0] i);
    rst = r;
    req = q;
    idx = i;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_all(0);
    check_all(1);
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    idx = 2'd0;
    din = 16'hA5C3;

    // Reset, then the first valid sample on channel 0 after four blanked cycles.
    step(1, 0, 2'd0);
    step(1, 0, 2'd0);
    repeat (6) step(0, 0, 2'd0);

    // Real switch 0 -> 2.
    step(0, 1, 2'd2);
    repeat (6) step(0, 0, 2'd0);

    // Request for the already committed channel.
    step(0, 1, 2'd2);
    repeat (2) step(0, 0, 2'd0);

    // Index 3: out of range on the 3-channel instance, real switch on the other.
    step(0, 1, 2'd3);
    repeat (6) step(0, 0, 2'd0);

    // Requests mid-settle and on the exit edge; lanes change during settle.
    step(0, 1, 2'd1);
    din = 16'h1E7B;
    step(0, 1, 2'd0);
    step(0, 0, 2'd0);
    din = 16'h9D42;
    step(0, 0, 2'd0);
    step(0, 1, 2'd2);
    repeat (4) step(0, 0, 2'd0);

    // Reset during the second cycle of a switch.
    step(0, 1, 2'd3);
    step(0, 0, 2'd0);
    step(1, 0, 2'd0);
    repeat (6) step(0, 0, 2'd0);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0) din = 16'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
